// File: rtl/i2c_rx_pkg.sv
// i2c_rx_pkg: shared definitions for the I2C receive byte sequencer.
//   BYTE_W_DEF : default number of data bits per byte
//   ACK_BIT    : value driven in the acknowledge slot to accept a byte
//   NACK_BIT   : value driven in the acknowledge slot to refuse a byte
//   rx_state_t : sequencer states (IDLE, SHIFT, ACK)
package i2c_rx_pkg;

  localparam int   BYTE_W_DEF = 8;
  localparam logic ACK_BIT    = 1'b0;
  localparam logic NACK_BIT   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2c_rx_shifter.sv
// i2c_rx_shifter: MSB-first shift register with a bit counter.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clr      : clear data and count (has priority over shift_en)
//   shift_en : shift bit_in into the LSB and increment count
//   bit_in   : sampled data bit
//   data     : shift register contents
//   count    : number of bits shifted since the last clear
module i2c_rx_shifter #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift_en,
  input  logic          bit_in,
  output logic [W-1:0]  data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  shreg_r;
  logic [CW-1:0] cnt_r;

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg_r <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (shift_en) begin
      shreg_r <= {shreg_r[W-2:0], bit_in};
      cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign data  = shreg_r;
  assign count = cnt_r;

endmodule

// File: rtl/i2c_rx_byte_ctrl.sv
// i2c_rx_byte_ctrl: receive-side byte sequencer between the I2C bit engine
// and the RX buffer. Assembles MSB-first bytes, hands them out through a
// one-entry valid/ready output register and decides ACK/NACK.
//   clk, rst             : clock, synchronous active-high reset
//   start, stop          : bus condition pulses (stop has priority)
//   bit_valid, bit_in    : one sampled SDA bit per pulse
//   last_byte, nack_last : NACK the final byte when both are set
//   byte_data/valid/ready: output register handshake
//   ack_req, ack_bit     : acknowledge slot request and value
//   ack_done             : acknowledge slot completed
//   overrun              : pulse, byte dropped because output was full
//   busy, bit_cnt        : status
module i2c_rx_byte_ctrl
  import i2c_rx_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      bit_valid,
  input  logic                      bit_in,
  input  logic                      last_byte,
  input  logic                      nack_last,
  output logic [BYTE_W-1:0]         byte_data,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic                      ack_req,
  output logic                      ack_bit,
  input  logic                      ack_done,
  output logic                      overrun,
  output logic                      busy,
  output logic [$clog2(BYTE_W):0]   bit_cnt
);

  localparam int CW = $clog2(BYTE_W) + 1;

  rx_state_t         state_r, state_nx_s;
  logic [BYTE_W-1:0] shreg_s;
  logic [CW-1:0]     cnt_s;
  logic              clr_s, shift_en_s, load_s, drop_s;
  logic              ack_req_nx_s, ack_bit_nx_s;
  logic              last_bit_s, out_free_s;
  logic [BYTE_W-1:0] completed_s;

  logic [BYTE_W-1:0] byte_data_r;
  logic              byte_valid_r, ack_req_r, ack_bit_r, overrun_r, busy_r;

  i2c_rx_shifter #(.W(BYTE_W), .CW(CW)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .shift_en (shift_en_s),
    .bit_in   (bit_in),
    .data     (shreg_s),
    .count    (cnt_s)
  );

  // The final bit is merged combinationally so the byte completes on its own bit_valid.
  assign completed_s = {shreg_s[BYTE_W-2:0], bit_in};
  assign last_bit_s  = bit_valid && (cnt_s == CW'(BYTE_W - 1));
  assign out_free_s  = !byte_valid_r || byte_ready;

  // Next-state, shifter control and acknowledge decision.
  always_comb begin
    state_nx_s   = state_r;
    clr_s        = 1'b0;
    shift_en_s   = 1'b0;
    load_s       = 1'b0;
    drop_s       = 1'b0;
    ack_req_nx_s = ack_req_r;
    ack_bit_nx_s = ack_bit_r;
    if (stop) begin
      state_nx_s   = IDLE;
      clr_s        = 1'b1;
      ack_req_nx_s = 1'b0;
    end else if (start) begin
      state_nx_s   = SHIFT;
      clr_s        = 1'b1;
      ack_req_nx_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s = IDLE;
        end
        SHIFT: begin
          if (last_bit_s) begin
            clr_s        = 1'b1;
            state_nx_s   = ACK;
            ack_req_nx_s = 1'b1;
            if (out_free_s) begin
              load_s       = 1'b1;
              ack_bit_nx_s = (last_byte && nack_last) ? NACK_BIT : ACK_BIT;
            end else begin
              drop_s       = 1'b1;
              ack_bit_nx_s = NACK_BIT;
            end
          end else if (bit_valid) begin
            shift_en_s = 1'b1;
          end else begin
            shift_en_s = 1'b0;
          end
        end
        ACK: begin
          if (ack_done) begin
            ack_req_nx_s = 1'b0;
            state_nx_s   = (ack_bit_r == NACK_BIT) ? IDLE : SHIFT;
          end else begin
            state_nx_s   = ACK;
          end
        end
        default: begin
          state_nx_s   = IDLE;
          clr_s        = 1'b1;
          ack_req_nx_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state, acknowledge and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ack_req_r <= 1'b0;
      ack_bit_r <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      ack_req_r <= ack_req_nx_s;
      ack_bit_r <= ack_bit_nx_s;
      overrun_r <= drop_s;
      busy_r    <= (state_nx_s != IDLE);
    end
  end

  // One-entry output register; a reload in the consuming cycle keeps it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_data_r  <= {BYTE_W{1'b0}};
      byte_valid_r <= 1'b0;
    end else if (load_s) begin
      byte_data_r  <= completed_s;
      byte_valid_r <= 1'b1;
    end else if (byte_valid_r && byte_ready) begin
      byte_valid_r <= 1'b0;
    end
  end

  assign byte_data  = byte_data_r;
  assign byte_valid = byte_valid_r;
  assign ack_req    = ack_req_r;
  assign ack_bit    = ack_bit_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;
  assign bit_cnt    = cnt_s;

endmodule

// File: doc/i2c_rx_byte_ctrl.md
# i2c_rx_byte_ctrl

Receive-side byte sequencer for the I2C block. It sits between the I2C bit engine, which delivers one sampled SDA bit per SCL rising edge, and the APB-side RX buffer. It gates and counts bit shifts, assembles MSB-first bytes, and hands each byte across a valid/ready interface through a one-entry output register. It also decides ACK/NACK for the acknowledge slot and requests it from the bit engine.

## Interface
- BYTE_W, 8, bits per data byte (bit counter sized $clog2(BYTE_W)+1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: START or repeated START detected on bus
- stop  in  1  pulse: STOP detected on bus
- bit_valid  in  1  pulse: bit_in holds a newly sampled data bit
- bit_in  in  1  sampled SDA value
- last_byte  in  1  level: current byte is final of the transfer (master-receiver mode)
- nack_last  in  1  cfg: NACK the final byte when last_byte=1
- byte_data  out  BYTE_W  output register contents
- byte_valid  out  1  output register full
- byte_ready  in  1  downstream accepts byte_data this cycle
- ack_req  out  1  request bit engine to drive the acknowledge slot
- ack_bit  out  1  0=ACK, 1=NACK; stable while ack_req=1
- ack_done  in  1  pulse: acknowledge slot completed
- overrun  out  1  one-cycle pulse: byte dropped because output register was full
- busy  out  1  state != IDLE
- bit_cnt  out  4  bits received in current byte, 0..BYTE_W-1

## Operation
- FSM states: IDLE, SHIFT, ACK.
- IDLE: bit_valid is ignored. start moves to SHIFT with bit_cnt=0 and the shift register cleared.
- SHIFT: each bit_valid does shreg <= {shreg[BYTE_W-2:0], bit_in} and increments bit_cnt. On the BYTE_W-th bit_valid:
  - Output register free (byte_valid=0, or byte_ready=1 in the same cycle): load byte_data with the completed byte and set byte_valid. ack_bit = last_byte & nack_last.
  - Output register full and not being consumed: drop the byte, leave byte_data unchanged, set ack_bit=1, pulse overrun.
  - In both cases bit_cnt returns to 0 and the FSM moves to ACK.
- ACK: ack_req=1 and bit_valid is ignored. On ack_done:
  - ack_bit=0: go to SHIFT.
  - ack_bit=1: go to IDLE. A NACK ends the receive sequence.
- Output register: byte_valid clears on byte_ready & byte_valid, unless it reloads in the same cycle. It is independent of the FSM and is not cleared by stop or start.
- stop in any state: go to IDLE. Partial byte is discarded, bit_cnt=0, ack_req=0.
- start in SHIFT or ACK (repeated START): go to SHIFT. Partial byte is discarded, bit_cnt=0, ack_req=0.
- stop and start in the same cycle: stop wins.
- start/stop coincident with the BYTE_W-th bit_valid: start/stop wins. The byte is not delivered and no overrun pulse is generated.
- rst: all state cleared regardless of FSM state, including mid-byte and mid-ACK.

## Timing
- Reset values: byte_data=0, byte_valid=0, ack_req=0, ack_bit=0, overrun=0, busy=0, bit_cnt=0, FSM=IDLE.
- All outputs are registered.
- byte_valid and ack_req rise in the cycle after the BYTE_W-th bit_valid (latency 1).
- overrun pulses in that same cycle, for exactly one cycle.
- ack_done may arrive in the first cycle ack_req is high. ack_req then drops the next cycle.
- bit_cnt updates the cycle after each bit_valid.
- Back-to-back bit_valid on consecutive cycles is supported.
- byte_ready combinationally affects only the next-state load decision. There is no combinational path to any output.

## Structure
- Package i2c_rx_pkg holds:
  - the state enum (IDLE, SHIFT, ACK)
  - BYTE_W default
  - ACK/NACK constants ACK_BIT=0, NACK_BIT=1
- Sub-module i2c_rx_shifter: shift register plus bit counter with inputs clr, shift_en, bit_in and outputs data and count. The FSM drives clr and shift_en.
- The output register and ACK logic stay in the top level.

## Test plan
- Basic byte: after start, feed bits 1,0,1,0,1,1,0,0 with byte_ready=1. Expect byte_data=0xAC and byte_valid high 1 cycle after the 8th bit, ack_req=1 with ack_bit=0. After ack_done, expect FSM in SHIFT.
- Overrun: byte_ready=0. Receive 0xAC, then 0xAF (1,0,1,0,1,1,1,1). Expect:
  - second ack_bit=1, one overrun pulse, byte_data remains 0xAC
  - after ack_done, FSM in IDLE
- Last-byte NACK: last_byte=1, nack_last=1, byte 0x5A. Expect byte_data=0x5A delivered, ack_bit=1, IDLE after ack_done, no overrun.
- Abort: stop after 3 bits. Expect IDLE, bit_cnt=0, no byte_valid. Then start plus 0x3C delivers 0x3C correctly.
- Repeated start: start pulse mid-byte after 5 bits. Expect bit_cnt=0 and FSM in SHIFT. The next 8 bits 0xC3 yield 0xC3.
- Simultaneous consume: byte_valid=1 holding 0xAC, byte_ready=1 in the same cycle as the 8th bit of 0x81. Expect byte_data=0x81, byte_valid stays 1, ack_bit=0, no overrun.
- Reset mid-ACK: assert rst while ack_req=1. The next cycle all outputs are at reset values.
